// File: rtl/c_drain_if.sv
// Result stream from the C drain toward the host dataOut path.
interface c_drain_if #(
    parameter int DATAW = 64
);
    logic [DATAW-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/c_drain.sv
// Walks the result rows of C out of the systolic array and serialises each
// row into DATAW-bit words on a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for a start pulse
// LOAD  | capture row Crow of C into the row buffer
// SEND  | present buffered words, one per handshake
// FIN   | one-cycle done pulse, then back to IDLE
module c_drain #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8,
    parameter int DATAW  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [$clog2(DIM)-1:0]  Crow,
    input  logic [DIM*BITS_C-1:0]   Cout,
    c_drain_if.master               dst,
    output logic                    busy,
    output logic                    done
);
    localparam int ROWW = DIM * BITS_C;
    localparam int WPR  = ROWW / DATAW;
    localparam int RW   = $clog2(DIM);
    localparam int IW   = (WPR > 1) ? $clog2(WPR) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(DIM - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WPR - 1);

    generate
        if (ROWW % DATAW != 0) begin : g_bad_width
            $error("c_drain: DIM*BITS_C must be a multiple of DATAW");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;

    state_t          state;
    logic [RW-1:0]   row;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_nxt;
    logic [ROWW-1:0] rowbuf;

    assign Crow    = row;
    assign idx_nxt = idx + 1'b1;

    // Word i of the buffered row; word 0 holds the lowest elements.
    function automatic logic [DATAW-1:0] word_of(input logic [ROWW-1:0] b,
                                                 input logic [IW-1:0]   i);
        return DATAW'(b >> (int'(i) * DATAW));
    endfunction

    // Drain sequencer; all stream outputs are registered so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            row           <= '0;
            idx           <= '0;
            rowbuf        <= '0;
            dst.out_data  <= '0;
            dst.out_valid <= 1'b0;
            dst.out_last  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        row   <= '0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    rowbuf        <= Cout;
                    idx           <= '0;
                    dst.out_data  <= Cout[DATAW-1:0];
                    dst.out_valid <= 1'b1;
                    dst.out_last  <= (row == ROW_LAST) && (IDX_LAST == '0);
                    state         <= SEND;
                end
                SEND: begin
                    if (dst.out_valid && dst.out_ready) begin
                        if (idx != IDX_LAST) begin
                            idx          <= idx_nxt;
                            dst.out_data <= word_of(rowbuf, idx_nxt);
                            dst.out_last <= (row == ROW_LAST) && (idx_nxt == IDX_LAST);
                        end else begin
                            dst.out_valid <= 1'b0;
                            dst.out_last  <= 1'b0;
                            if (row != ROW_LAST) begin
                                row   <= row + 1'b1;
                                state <= LOAD;
                            end else begin
                                done  <= 1'b1;
                                state <= FIN;
                            end
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c_drain.sv
// Directed bench for c_drain: default build (DIM=8, WPR=2) and a DIM=4 build (WPR=1).
module tb_c_drain;
    logic clk = 1'b0;
    logic rst;
    logic start8, start4;
    logic [2:0]   crow8;
    logic [1:0]   crow4;
    logic [127:0] cout8;
    logic [63:0]  cout4;
    logic busy8, done8, busy4, done4;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t0_8   = 0;
    int t0_4   = 0;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        logic        last;
    } word_t;

    word_t q8[$];
    word_t q4[$];
    int    d8[$];
    int    d4[$];

    always #5 clk = ~clk;

    c_drain_if #(.DATAW(64)) if8 ();
    c_drain_if #(.DATAW(64)) if4 ();

    c_drain #(.BITS_C(16), .DIM(8), .DATAW(64)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .Crow(crow8), .Cout(cout8),
        .dst(if8.master), .busy(busy8), .done(done8)
    );

    c_drain #(.BITS_C(16), .DIM(4), .DATAW(64)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .Crow(crow4), .Cout(cout4),
        .dst(if4.master), .busy(busy4), .done(done4)
    );

    // Array model: C[r][k] = r*16 + k
    always_comb begin
        cout8 = '0;
        for (int k = 0; k < 8; k++) cout8[k*16 +: 16] = 16'(int'(crow8) * 16 + k);
        cout4 = '0;
        for (int k = 0; k < 4; k++) cout4[k*16 +: 16] = 16'(int'(crow4) * 16 + k);
    end

    // Log handshakes and done pulses with the cycle number relative to start.
    always @(posedge clk) begin
        word_t w;
        if (!rst) begin
            if (if8.out_valid && if8.out_ready) begin
                w.cyc = cyc - t0_8; w.data = if8.out_data; w.last = if8.out_last;
                q8.push_back(w);
            end
            if (if4.out_valid && if4.out_ready) begin
                w.cyc = cyc - t0_4; w.data = if4.out_data; w.last = if4.out_last;
                q4.push_back(w);
            end
            if (done8) d8.push_back(cyc - t0_8);
            if (done4) d4.push_back(cyc - t0_4);
        end
        cyc = cyc + 1;
    end

    function automatic logic [63:0] exp_word(int r, int w);
        logic [63:0] v;
        for (int j = 0; j < 4; j++) v[j*16 +: 16] = 16'(r * 16 + w * 4 + j);
        return v;
    endfunction

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go8();
        q8.delete(); d8.delete();
        start8 = 1'b1;
        t0_8   = cyc;
        tick();
        start8 = 1'b0;
    endtask

    task automatic wait_done8(int budget);
        int n = 0;
        while (d8.size() == 0 && n < budget) begin tick(); n++; end
        chk("done8_seen", 64'(d8.size() > 0), 64'd1);
        tick(4);
    endtask

    // Expects 16 words; words from index bp_at onward are delayed by bp_len cycles.
    task automatic check_drain8(string tag, int bp_at, int bp_len);
        int n;
        chk({tag, "_nwords"}, 64'(q8.size()), 64'd16);
        n = (q8.size() < 16) ? q8.size() : 16;
        for (int i = 0; i < n; i++) begin
            int r = i / 2;
            int w = i % 2;
            int ec = 2 + 3 * r + w + ((i >= bp_at) ? bp_len : 0);
            chk($sformatf("%s_data%0d", tag, i), q8[i].data, exp_word(r, w));
            chk($sformatf("%s_cyc%0d", tag, i), 64'(q8[i].cyc), 64'(ec));
            chk($sformatf("%s_last%0d", tag, i), 64'(q8[i].last), 64'(i == 15));
        end
        chk({tag, "_ndone"}, 64'(d8.size()), 64'd1);
        if (d8.size() > 0) chk({tag, "_done_cyc"}, 64'(d8[0]), 64'(25 + bp_len));
    endtask

    initial begin
        rst = 1'b1; start8 = 1'b1; start4 = 1'b0;
        if8.out_ready = 1'b1; if4.out_ready = 1'b1;

        // Reset held with start high
        tick(2);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_valid", 64'(if8.out_valid), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_crow", 64'(crow8), 64'd0);
        chk("rst_last", 64'(if8.out_last), 64'd0);
        rst = 1'b0; start8 = 1'b0;
        q8.delete(); d8.delete();
        tick(4);
        chk("idle_busy", 64'(busy8), 64'd0);
        chk("idle_nwords", 64'(q8.size()), 64'd0);

        // Full drain, ready held high
        go8();
        chk("first_valid_c1", 64'(if8.out_valid), 64'd0);
        tick();
        chk("first_valid_c2", 64'(if8.out_valid), 64'd1);
        chk("busy_c2", 64'(busy8), 64'd1);
        wait_done8(60);
        check_drain8("full", 16, 0);
        chk("full_busy_after", 64'(busy8), 64'd0);

        // Backpressure on row 2 word 1 (cycles 9..11)
        go8();
        tick(8);
        if8.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_valid%0d", i), 64'(if8.out_valid), 64'd1);
            chk($sformatf("bp_data%0d", i), if8.out_data, 64'h0027_0026_0025_0024);
            chk($sformatf("bp_last%0d", i), 64'(if8.out_last), 64'd0);
            tick();
        end
        if8.out_ready = 1'b1;
        wait_done8(60);
        check_drain8("bp", 5, 3);

        // start pulses at cycles 4 and 12 are ignored
        go8();
        tick(3);
        start8 = 1'b1; tick(); start8 = 1'b0;
        tick(7);
        start8 = 1'b1; tick(); start8 = 1'b0;
        wait_done8(60);
        check_drain8("ign", 16, 0);
        tick(6);
        chk("ign_nwords_after", 64'(q8.size()), 64'd16);
        chk("ign_busy_after", 64'(busy8), 64'd0);

        // Reset after the 5th accepted word
        go8();
        tick(8);
        chk("mid_nwords", 64'(q8.size()), 64'd5);
        rst = 1'b1;
        tick();
        chk("mid_valid", 64'(if8.out_valid), 64'd0);
        chk("mid_busy", 64'(busy8), 64'd0);
        chk("mid_done", 64'(done8), 64'd0);
        chk("mid_crow", 64'(crow8), 64'd0);
        rst = 1'b0;
        tick(6);
        chk("mid_ndone", 64'(d8.size()), 64'd0);
        chk("mid_nwords_after", 64'(q8.size()), 64'd5);
        go8();
        wait_done8(60);
        check_drain8("post_rst", 16, 0);

        // DIM=4 build, one word per row
        q4.delete(); d4.delete();
        start4 = 1'b1; t0_4 = cyc; tick(); start4 = 1'b0;
        begin
            int n = 0;
            while (d4.size() == 0 && n < 40) begin tick(); n++; end
        end
        tick(3);
        chk("d4_nwords", 64'(q4.size()), 64'd4);
        for (int i = 0; i < 4 && i < q4.size(); i++) begin
            chk($sformatf("d4_data%0d", i), q4[i].data, exp_word(i, 0));
            chk($sformatf("d4_cyc%0d", i), 64'(q4[i].cyc), 64'(2 + 2 * i));
            chk($sformatf("d4_last%0d", i), 64'(q4[i].last), 64'(i == 3));
        end
        chk("d4_ndone", 64'(d4.size()), 64'd1);
        if (d4.size() > 0) chk("d4_done_cyc", 64'(d4[0]), 64'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
